// File: rtl/id_pkg.sv
// Shared definitions for the id_ctrl decode/execute sequencer:
// opcodes, instruction field positions, ALU op codes, FSM state encoding
// and the decoded-instruction class struct.
package id_pkg;

  // Opcodes (instruction[15:12])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field bit positions
  localparam int OP_HI = 15, OP_LO = 12;
  localparam int RD_HI = 11, RD_LO = 8;
  localparam int RS_HI = 7,  RS_LO = 4;
  localparam int RT_HI = 3,  RT_LO = 0;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEMWR, S_MEMWAIT, S_WB, S_DONE, S_HALTED
  } state_e;

  typedef struct packed {
    logic       isAlu;
    logic       isLdi;
    logic       isLd;
    logic       isSt;
    logic       isJmp;
    logic       isBz;
    logic       isHalt;
    logic       isIllegal;
    logic [2:0] aluOp;
  } dec_t;

endpackage

// File: rtl/id_ctrl_if.sv
// Control/status bundle between the id_ctrl sequencer (master) and the
// datapath / fetch / memory side (slave).
interface id_ctrl_if;
  logic        instValid;
  logic [15:0] instruction;
  logic        MFC;
  logic        zeroFlag;
  logic [3:0]  regRdA;
  logic        regRdEn;
  logic [3:0]  regWrAddr;
  logic        regWrEn;
  logic [2:0]  aluOp;
  logic        aluOutEn;
  logic [15:0] imm;
  logic        immOutEn;
  logic        marLoad;
  logic        mdrReadEn;
  logic        mdrWriteEn;
  logic        mdrROutEn;
  logic        memEn;
  logic        R_W;
  logic        pcLoad;
  logic        execDone;
  logic        halted;
  logic        illegal;
  logic        memFault;

  modport master (
    input  instValid, instruction, MFC, zeroFlag,
    output regRdA, regRdEn, regWrAddr, regWrEn, aluOp, aluOutEn, imm,
           immOutEn, marLoad, mdrReadEn, mdrWriteEn, mdrROutEn, memEn, R_W,
           pcLoad, execDone, halted, illegal, memFault
  );

  modport slave (
    output instValid, instruction, MFC, zeroFlag,
    input  regRdA, regRdEn, regWrAddr, regWrEn, aluOp, aluOutEn, imm,
           immOutEn, marLoad, mdrReadEn, mdrWriteEn, mdrROutEn, memEn, R_W,
           pcLoad, execDone, halted, illegal, memFault
  );
endinterface

// File: rtl/id_decode.sv
// Combinational opcode classifier: instruction class flags plus ALU op.
module id_decode
  import id_pkg::*;
(
  input  logic [3:0] op_i,
  output dec_t       dec_o
);

  // Classify the opcode; A-E fall out as illegal
  always_comb begin
    dec_o           = '0;
    dec_o.isAlu     = (op_i >= OP_ADD) && (op_i <= OP_OR);
    dec_o.isLdi     = (op_i == OP_LDI);
    dec_o.isLd      = (op_i == OP_LD);
    dec_o.isSt      = (op_i == OP_ST);
    dec_o.isJmp     = (op_i == OP_JMP);
    dec_o.isBz      = (op_i == OP_BZ);
    dec_o.isHalt    = (op_i == OP_HALT);
    dec_o.isIllegal = (op_i > OP_BZ) && (op_i < OP_HALT);
    case (op_i)
      OP_SUB:  dec_o.aluOp = ALU_SUB;
      OP_AND:  dec_o.aluOp = ALU_AND;
      OP_OR:   dec_o.aluOp = ALU_OR;
      default: dec_o.aluOp = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ctrl.sv
// Instruction decode/execute sequencer. Latches IR when fetch completes,
// then steps the register file / ALU / MAR / MDR / memory / PC strobes and
// pulses execDone to kick off the next fetch. All strobes are decoded from
// the state register so reset removes them asynchronously.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode halts the core).
module id_ctrl
  import id_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int IMM_W       = 8
) (
  input  logic     clk,
  input  logic     reset,
  id_ctrl_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;
  dec_t              dec;

  id_decode u_dec (.op_i(ir_q[OP_HI:OP_LO]), .dec_o(dec));

  assign bus.memFault = fault_q;

  // State, latched instruction, MFC timeout counter and sticky fault
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and strobe decode; counter only runs while in MEMWAIT
  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    cnt_d          = '0;
    fault_d        = fault_q;
    bus.regRdA     = '0;
    bus.regRdEn    = 1'b0;
    bus.regWrAddr  = '0;
    bus.regWrEn    = 1'b0;
    bus.aluOp      = '0;
    bus.aluOutEn   = 1'b0;
    bus.imm        = '0;
    bus.immOutEn   = 1'b0;
    bus.marLoad    = 1'b0;
    bus.mdrReadEn  = 1'b0;
    bus.mdrWriteEn = 1'b0;
    bus.mdrROutEn  = 1'b0;
    bus.memEn      = 1'b0;
    bus.R_W        = 1'b1;
    bus.pcLoad     = 1'b0;
    bus.execDone   = 1'b0;
    bus.halted     = 1'b0;
    bus.illegal    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instValid) begin
          ir_d    = bus.instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.illegal = dec.isIllegal;
`ifdef ILLEGAL_TRAP_EN
        state_d = dec.isIllegal ? S_HALTED : S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (dec.isAlu) begin
          bus.regRdA  = ir_q[RS_HI:RS_LO];
          bus.regRdEn = 1'b1;
          bus.aluOp   = dec.aluOp;
          state_d     = S_WB;
        end else if (dec.isLdi) begin
          state_d = S_WB;
        end else if (dec.isLd || dec.isSt) begin
          bus.regRdA  = ir_q[RS_HI:RS_LO];
          bus.regRdEn = 1'b1;
          bus.marLoad = 1'b1;
          state_d     = dec.isLd ? S_MEMWAIT : S_MEMWR;
        end else if (dec.isJmp || (dec.isBz && bus.zeroFlag)) begin
          bus.regRdA  = ir_q[RS_HI:RS_LO];
          bus.regRdEn = 1'b1;
          bus.pcLoad  = 1'b1;
          state_d     = S_DONE;
        end else if (dec.isHalt) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_DONE;  // NOP, untaken BZ, illegal treated as NOP
        end
      end
      S_MEMWR: begin
        bus.regRdA     = ir_q[RD_HI:RD_LO];
        bus.regRdEn    = 1'b1;
        bus.mdrWriteEn = 1'b1;
        state_d        = S_MEMWAIT;
      end
      S_MEMWAIT: begin
        bus.memEn     = 1'b1;
        bus.R_W       = dec.isLd;
        bus.mdrReadEn = dec.isLd;
        cnt_d         = cnt_q + 1'b1;
        if (bus.MFC) begin
          state_d = dec.isLd ? S_WB : S_DONE;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WB: begin
        bus.regWrEn   = 1'b1;
        bus.regWrAddr = ir_q[RD_HI:RD_LO];
        bus.aluOutEn  = dec.isAlu;
        bus.immOutEn  = dec.isLdi;
        bus.mdrROutEn = dec.isLd;
        if (dec.isLdi) bus.imm = {{(16 - IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
        state_d = S_DONE;
      end
      S_DONE: begin
        bus.execDone = 1'b1;
        state_d      = S_IDLE;
      end
      S_HALTED: bus.halted = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_id_ctrl.sv
// Self-checking bench for id_ctrl: directed cases from the test plan plus a
// randomized instruction stream, compared cycle by cycle against a list of
// expected bus phases derived from each instruction class.
module tb_id_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ctrl_if bus();
  id_ctrl #(.MEM_TIMEOUT(16), .IMM_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  typedef struct packed {
    logic [3:0]  rdA;  logic rdEn;  logic [3:0] wa;  logic we;
    logic [2:0]  op;   logic aluEn; logic [15:0] imm; logic immEn;
    logic mar; logic mdrR; logic mdrW; logic mdrO; logic mem; logic rw;
    logic pc;  logic done; logic halted; logic ill; logic fault;
  } out_t;

  int   checks = 0;
  int   failures = 0;
  bit   mf;             // model of the sticky memFault
  bit   halts;          // current instruction ends in HALTED
  out_t exp_q[$];
  bit   mfc_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic out_t observe();
    out_t o;
    o.rdA = bus.regRdA;     o.rdEn = bus.regRdEn;   o.wa = bus.regWrAddr;
    o.we = bus.regWrEn;     o.op = bus.aluOp;       o.aluEn = bus.aluOutEn;
    o.imm = bus.imm;        o.immEn = bus.immOutEn; o.mar = bus.marLoad;
    o.mdrR = bus.mdrReadEn; o.mdrW = bus.mdrWriteEn; o.mdrO = bus.mdrROutEn;
    o.mem = bus.memEn;      o.rw = bus.R_W;         o.pc = bus.pcLoad;
    o.done = bus.execDone;  o.halted = bus.halted;  o.ill = bus.illegal;
    o.fault = bus.memFault;
    return o;
  endfunction

  function automatic out_t idle_v();
    out_t o = '0;
    o.rw = 1'b1;
    o.fault = mf;
    return o;
  endfunction

  task automatic push(input out_t o, input bit m);
    exp_q.push_back(o);
    mfc_q.push_back(m);
  endtask

  // Expected phase list for one instruction; wt = MEMWAIT cycle on which
  // MFC rises (1..16), anything larger means MFC never comes.
  task automatic build(input logic [15:0] ins, input bit zf, input int wt);
    logic [3:0] op, rd, rs;
    out_t o;
    bit ill;
    int n;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4];
    exp_q.delete(); mfc_q.delete(); halts = 0;
    ill = (op >= 4'hA) && (op <= 4'hE);
    o = idle_v(); o.ill = ill; push(o, 0);                  // DECODE
`ifdef ILLEGAL_TRAP_EN
    if (ill) begin halts = 1; return; end
`endif
    o = idle_v();                                           // EXEC
    if (op >= 1 && op <= 4) begin
      o.rdA = rs; o.rdEn = 1; o.op = 3'(op - 1); push(o, 0);
      o = idle_v(); o.we = 1; o.wa = rd; o.aluEn = 1; push(o, 0);
    end else if (op == 5) begin
      push(o, 0);
      o = idle_v(); o.we = 1; o.wa = rd; o.immEn = 1; o.imm = {8'h00, ins[7:0]}; push(o, 0);
    end else if (op == 6 || op == 7) begin
      o.rdA = rs; o.rdEn = 1; o.mar = 1; push(o, 0);
      if (op == 7) begin
        o = idle_v(); o.rdA = rd; o.rdEn = 1; o.mdrW = 1; push(o, 0);
      end
      n = (wt >= 1 && wt <= 16) ? wt : 16;
      for (int k = 1; k <= n; k++) begin
        o = idle_v(); o.mem = 1; o.rw = (op == 6); o.mdrR = (op == 6);
        push(o, k == wt);
      end
      if (wt > 16) mf = 1;
      else if (op == 6) begin
        o = idle_v(); o.we = 1; o.wa = rd; o.mdrO = 1; push(o, 0);
      end
    end else if (op == 8 || (op == 9 && zf)) begin
      o.rdA = rs; o.rdEn = 1; o.pc = 1; push(o, 0);
    end else if (op == 4'hF) begin
      push(o, 0); halts = 1; return;
    end else begin
      push(o, 0);
    end
    o = idle_v(); o.done = 1; push(o, 0);                   // DONE
  endtask

  // Call at a low clock phase with the DUT idle. rst_at >= 0 asserts reset
  // right after checking that cycle.
  task automatic run(input string nm, input logic [15:0] ins, input bit zf,
                     input int wt, input int rst_at);
    out_t o, h;
    build(ins, zf, wt);
    bus.zeroFlag = zf; bus.instruction = ins; bus.instValid = 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      bus.instValid = 0; bus.MFC = mfc_q[i];
      #1;
      o = observe();
      chk($sformatf("%s c%0d", nm, i + 1), o, exp_q[i]);
      chk($sformatf("%s onebus c%0d", nm, i + 1),
          64'($countones({o.rdEn, o.aluEn, o.immEn, o.mdrO}) <= 1), 64'd1);
      if (i == rst_at) begin
        reset = 1; bus.MFC = 0; mf = 0;
        #1 chk($sformatf("%s async rst", nm), observe(), idle_v());
        @(negedge clk); reset = 0;
        return;
      end
    end
    @(negedge clk); bus.MFC = 0;
    if (halts) begin
      h = idle_v(); h.halted = 1;
      for (int k = 0; k < 4; k++) begin
        #1 chk($sformatf("%s halted%0d", nm, k), observe(), h);
        bus.instValid = 1; bus.instruction = 16'h1234;
        @(negedge clk);
      end
      bus.instValid = 0;
    end else begin
      #1 chk($sformatf("%s idle", nm), observe(), idle_v());
    end
  endtask

  task automatic do_reset();
    reset = 1; mf = 0;
    bus.instValid = 0; bus.instruction = '0; bus.MFC = 0; bus.zeroFlag = 0;
    repeat (2) @(negedge clk);
    #1 chk("reset", observe(), idle_v());
    reset = 0;
  endtask

  initial begin
    logic [3:0] rop;
    int opmax;
    do_reset();
    run("ADD",    16'h1234, 0, 0, -1);
    run("LD",     16'h6150, 0, 3, -1);
    run("ST",     16'h7260, 0, 99, -1);   // timeout, memFault sticks
    run("BZ0",    16'h9070, 0, 0, -1);
    run("BZ1",    16'h9070, 1, 0, -1);
    run("LDI",    16'h53AB, 0, 0, -1);
    run("LD16",   16'h6C40, 0, 16, -1);   // MFC on the last allowed cycle
    run("ST1",    16'h7D20, 0, 1, -1);
    run("JMP",    16'h80E0, 0, 0, -1);
`ifdef ILLEGAL_TRAP_EN
    opmax = 9;
`else
    opmax = 14;
`endif
    for (int t = 0; t < 40; t++) begin
      rop = 4'($urandom_range(0, opmax));
      run($sformatf("RND%0d", t), {rop, 12'($urandom)}, 1'($urandom),
          int'($urandom_range(1, 18)), -1);
    end
    run("ILL",    16'hA000, 0, 0, -1);
`ifdef ILLEGAL_TRAP_EN
    do_reset();
`endif
    run("HALT",   16'hF000, 0, 0, -1);
    do_reset();
    run("ADDRST", 16'h1234, 0, 0, 2);     // reset during WB
    run("ADD2",   16'h2345, 0, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ctrl.md
Name: id_ctrl

Overview:
- Instruction decode/execute sequencer directly downstream of the instruction-fetch stage.
- Accepts the 16-bit word held in IR once fetch completes, then decodes it.
- Sequences the bus-level control strobes for register file, ALU, MAR, MDR, MEM and PC.
- Pulses execDone so the fetch controller starts the next fetch.

Parameters:
- MEM_TIMEOUT, 16: max cycles to wait for MFC before declaring memFault.
- IMM_W, 8: immediate field width for LDI, zero-extended to 16 bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- instValid  in  1  fetch complete, instruction stable
- instruction  in  16  IR contents
- MFC  in  1  memory function complete
- zeroFlag  in  1  ALU zero flag from last ALU op
- regRdA  out  4  register read address driven onto bus
- regRdEn  out  1  register file drives bus
- regWrAddr  out  4  destination register
- regWrEn  out  1  register file loads from bus
- aluOp  out  3  0 add, 1 sub, 2 and, 3 or
- aluOutEn  out  1  ALU result onto bus
- imm  out  16  zero-extended immediate
- immOutEn  out  1  imm onto bus
- marLoad  out  1  MAR loads from bus
- mdrReadEn  out  1  MDR captures memory data
- mdrWriteEn  out  1  MDR loads from bus for write
- mdrROutEn  out  1  MDR drives bus
- memEn  out  1  memory enable
- R_W  out  1  1 = read, 0 = write
- pcLoad  out  1  PC loads from bus
- execDone  out  1  one-cycle pulse, request next fetch
- halted  out  1  HALT executed
- illegal  out  1  one-cycle pulse on undefined opcode
- memFault  out  1  sticky, MFC timeout

Behaviour:
- Instruction format: op[15:12], rd[11:8], rs[7:4], rt[3:0], imm8 = [7:0].
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR: rd = rs op rt
  - 5 LDI
  - 6 LD: rd = M[rs]
  - 7 ST: M[rs] = rd
  - 8 JMP: pc = rs
  - 9 BZ: pc = rs if zeroFlag
  - F HALT
  - A-E illegal
- Reset: all outputs 0 except R_W = 1; state IDLE; latched instruction 0; timeout counter 0.
- States: IDLE, DECODE, EXEC, MEMWR, MEMWAIT, WB, DONE, HALTED.
- IDLE: instValid is sampled only here and ignored in every other state. When high, the instruction is latched and the FSM goes to DECODE.
- DECODE: 1 cycle, no strobes.
- EXEC by class:
  - ALU: regRdA = rs, regRdEn, aluOp driven; the ALU takes rt internally. Next WB.
  - LDI: no strobe. Next WB.
  - LD/ST: regRdA = rs, regRdEn, marLoad. LD goes to MEMWAIT; ST goes to MEMWR.
  - JMP, or BZ with zeroFlag = 1: regRdA = rs, regRdEn, pcLoad. Next DONE.
  - NOP, or BZ with zeroFlag = 0: no strobe. Next DONE.
  - HALT: next HALTED.
- MEMWR: regRdA = rd, regRdEn, mdrWriteEn for 1 cycle. Next MEMWAIT.
- MEMWAIT: memEn held high. LD uses R_W = 1 with mdrReadEn; ST uses R_W = 0. The counter increments each cycle.
  - MFC = 1: LD goes to WB, ST goes to DONE.
  - Counter reaches MEM_TIMEOUT-1 without MFC: memFault is set and the FSM goes to DONE.
- WB: regWrEn with regWrAddr = rd, plus the bus source:
  - ALU: aluOutEn
  - LDI: immOutEn
  - LD: mdrROutEn
- DONE: execDone high for 1 cycle. Next IDLE.
- Latency from instValid acceptance edge to execDone high:
  - ALU/LDI: 4 cycles
  - NOP/JMP/BZ: 3 cycles
  - LD: 4 + MFC wait cycles
  - ST: 4 + MFC wait cycles
- At most one bus driver (regRdEn, aluOutEn, immOutEn, mdrROutEn) is active in any cycle.
- HALTED: halted = 1. No further execDone. Exit only via reset.
- Illegal opcode: illegal pulses in DECODE; then the instruction is treated as NOP.
- memFault clears only on reset.
- Reset asserted mid-instruction: all strobes drop immediately; no partial register write completes.

Optional Feature:
- ILLEGAL_TRAP_EN.
- Defined: an illegal opcode pulses illegal and the FSM enters HALTED, with halted = 1.
- Undefined: illegal pulses and execution continues as NOP, giving execDone 3 cycles after acceptance.

Decomposition:
- Package id_pkg holds:
  - opcode localparams (OP_NOP ... OP_HALT)
  - state encoding
  - ALU op codes
  - field bit positions
- One sub-module, id_decode: combinational classification of the opcode into isAlu, isLdi, isLd, isSt, isJmp, isBz, isHalt, isIllegal, plus aluOp.
- The FSM stays in id_ctrl.

Test Plan:
- ADD: reset, then instruction 16'h1234 with instValid pulse.
  - EXEC: regRdA = 3, aluOp = 0.
  - WB: regWrEn with regWrAddr = 2, aluOutEn.
  - execDone 4 cycles after acceptance.
- LD: 16'h6150 with MFC raised 3 cycles into MEMWAIT.
  - EXEC: marLoad with regRdA = 5.
  - MEMWAIT: memEn = 1, R_W = 1 for 3 cycles.
  - WB: mdrROutEn with regWrEn, regWrAddr = 1.
  - execDone follows WB.
- ST: 16'h7260 with MFC never raised.
  - MEMWR: mdrWriteEn with regRdA = 2.
  - MEMWAIT: R_W = 0 for 16 cycles.
  - memFault = 1, then execDone.
- BZ: 16'h9070 with zeroFlag = 0, then 1.
  - zeroFlag = 0: no pcLoad, execDone at 3 cycles.
  - zeroFlag = 1: pcLoad with regRdA = 7.
- Illegal/HALT: 16'hA000, then 16'hF000.
  - 16'hA000: illegal pulse; without the macro execDone follows, with the macro halted = 1.
  - 16'hF000: halted = 1; further instValid pulses produce no strobes.
- Reset mid-instruction: assert reset during WB of an ADD.
  - All outputs return to reset values asynchronously.
  - regWrEn falls immediately.
